// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 4;
  localparam int ARB_DATA_W = 16;

  // Requester ids, also the encoding of the round-robin pointer.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_rsp.sv
// Per-port read-return register: strobes one cycle after a granted read and
// holds the captured data until the next read by the same port.
module mem_arb_rsp #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fire,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  // Capture memory data only on this port's granted reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_fire;
      if (i_fire) r_rdata <= i_rdata;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// load/store stage (requester 0) and the debug/DMA port (requester 1), with a
// bounded lock for read-modify-write sequences.
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_lock0,
  input  logic              i_lock1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // Counter only needs to reach MAX_LOCK-1 before the forced release.
  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_t       r_state, w_state_nxt;
  logic             r_rr, w_rr_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic             w_gnt0, w_gnt1;

  // State, round-robin pointer and lock counter; reset drops any ownership.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ARB_IDLE;
      r_rr       <= REQ_CPU;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr       <= w_rr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Grant decode and next-state; grants are held low throughout reset.
  always_comb begin
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr;
    w_lock_cnt_nxt = r_lock_cnt;
    if (!i_reset) begin
      unique case (r_state)
        ARB_IDLE: begin
          if (i_req0 && (!i_req1 || r_rr == REQ_CPU)) w_gnt0 = 1'b1;
          else if (i_req1)                             w_gnt1 = 1'b1;
          if (w_gnt0) begin
            w_rr_nxt = REQ_DBG;
            if (i_lock0) begin
              w_state_nxt    = ARB_OWN0;
              w_lock_cnt_nxt = CNT_W'(1);
            end
          end
          if (w_gnt1) begin
            w_rr_nxt = REQ_CPU;
            if (i_lock1) begin
              w_state_nxt    = ARB_OWN1;
              w_lock_cnt_nxt = CNT_W'(1);
            end
          end
        end
        ARB_OWN0: begin
          w_gnt0 = i_req0;
          // Release on lock drop or at the cap; the other side is favoured next.
          if (!(i_req0 && i_lock0) || r_lock_cnt == CNT_LAST) begin
            w_state_nxt = ARB_IDLE;
            w_rr_nxt    = REQ_DBG;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
          end
        end
        ARB_OWN1: begin
          w_gnt1 = i_req1;
          if (!(i_req1 && i_lock1) || r_lock_cnt == CNT_LAST) begin
            w_state_nxt = ARB_IDLE;
            w_rr_nxt    = REQ_CPU;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  // Memory mux: idle bus drives zeros so the memory sees no stray write.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt0) begin
      o_mem_we    = i_we0;
      o_mem_addr  = i_addr0;
      o_mem_wdata = i_wdata0;
    end else if (w_gnt1) begin
      o_mem_we    = i_we1;
      o_mem_addr  = i_addr1;
      o_mem_wdata = i_wdata1;
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

  mem_arb_rsp #(.DATA_W(DATA_W)) u_rsp0 (
    .i_clk    (i_clk),
    .i_rst    (i_reset),
    .i_fire   (w_gnt0 && !i_we0),
    .i_rdata  (i_mem_rdata),
    .o_rvalid (o_rvalid0),
    .o_rdata  (o_rdata0)
  );

  mem_arb_rsp #(.DATA_W(DATA_W)) u_rsp1 (
    .i_clk    (i_clk),
    .i_rst    (i_reset),
    .i_fire   (w_gnt1 && !i_we1),
    .i_rdata  (i_mem_rdata),
    .o_rvalid (o_rvalid1),
    .o_rdata  (o_rdata1)
  );

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Bench for mem_data_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against an ownership/favour model of the arbiter.
module tb_mem_data_arbiter;

  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [3:0]  mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_data_arbiter #(.ADDR_W(4), .DATA_W(16), .MAX_LOCK(MAX_LOCK)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
    .i_we0(we0), .i_we1(we1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] preload(input int i);
    if (i == 3)      return 16'h2233;
    else if (i == 5) return 16'h3344;
    else             return 16'hA000 | 16'(i);
  endfunction

  // Data memory: combinational read, write on the edge ending the cycle;
  // reloaded whenever reset is held across an edge.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) mem[i] <= preload(i);
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 none), granted cycles held, favoured id, shadow memory.
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_favor = 0;
  logic        m_rv0 = 0, m_rv1 = 0;
  logic [15:0] m_rd0 = 0, m_rd1 = 0;
  logic [15:0] ref_mem [16];

  always @(negedge clk) begin
    int win;
    logic [3:0] e_addr;
    logic [15:0] e_wd;
    logic e_we;
    if (rst)                win = -1;
    else if (m_owner == 0)  win = req0 ? 0 : -1;
    else if (m_owner == 1)  win = req1 ? 1 : -1;
    else if (req0 && req1)  win = m_favor;
    else if (req0)          win = 0;
    else if (req1)          win = 1;
    else                    win = -1;
    e_we   = (win == 0) ? we0    : (win == 1) ? we1    : 1'b0;
    e_addr = (win == 0) ? addr0  : (win == 1) ? addr1  : 4'd0;
    e_wd   = (win == 0) ? wdata0 : (win == 1) ? wdata1 : 16'd0;
    chk("m_gnt0",   {31'd0, gnt0},   {31'd0, win == 0});
    chk("m_gnt1",   {31'd0, gnt1},   {31'd0, win == 1});
    chk("m_mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("m_addr",   {28'd0, mem_addr}, {28'd0, e_addr});
    chk("m_wdata",  {16'd0, mem_wdata}, {16'd0, e_wd});
    chk("m_rvalid0", {31'd0, rvalid0}, {31'd0, rst ? 1'b0 : m_rv0});
    chk("m_rvalid1", {31'd0, rvalid1}, {31'd0, rst ? 1'b0 : m_rv1});
    chk("m_rdata0", {16'd0, rdata0}, {16'd0, rst ? 16'd0 : m_rd0});
    chk("m_rdata1", {16'd0, rdata1}, {16'd0, rst ? 16'd0 : m_rd1});
    // Advance to what the coming edge must produce.
    if (rst) begin
      m_owner = -1; m_held = 0; m_favor = 0;
      m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = preload(i);
    end else begin
      m_rv0 = (win == 0) && !we0;
      m_rv1 = (win == 1) && !we1;
      if (m_rv0) m_rd0 = ref_mem[addr0];
      if (m_rv1) m_rd1 = ref_mem[addr1];
      if (win >= 0 && e_we) ref_mem[e_addr] = e_wd;
      if (m_owner >= 0) begin
        if (!((m_owner == 0) ? (req0 && lock0) : (req1 && lock1)) || m_held == MAX_LOCK - 1) begin
          m_favor = 1 - m_owner;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else if (win >= 0) begin
        m_favor = 1 - win;
        if ((win == 0) ? lock0 : lock1) begin
          m_owner = win;
          m_held  = 1;
        end
      end
    end
  end

  // One cycle of stimulus: inputs change just after the edge, checks follow at negedge.
  task automatic step(input logic r0, l0, w0, input logic [3:0] a0, input logic [15:0] d0,
                      input logic r1, l1, w1, input logic [3:0] a1, input logic [15:0] d1);
    @(posedge clk); #1;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 4'd0, 16'd0, 0, 0, 0, 4'd0, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; lock1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_outs", {27'd0, gnt0, gnt1, mem_we, rvalid0, rvalid1}, 32'd0);
    chk("rst_rdata0", {16'd0, rdata0}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle();
    chk("idle_outs", {27'd0, gnt0, gnt1, mem_we, rvalid0, rvalid1}, 32'd0);
    chk("idle_addr", {28'd0, mem_addr}, 32'd0);

    // Single read of preloaded address 3 by requester 0.
    step(1, 0, 0, 4'd3, 16'd0, 0, 0, 0, 4'd0, 16'd0);
    chk("rd3_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rd3_addr", {28'd0, mem_addr}, 32'd3);
    idle();
    chk("rd3_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("rd3_rdata0", {16'd0, rdata0}, 32'h2233);
    idle();
    chk("rd3_rvalid0_off", {31'd0, rvalid0}, 32'd0);
    chk("rd3_rdata0_hold", {16'd0, rdata0}, 32'h2233);

    // Requester 1 alone, leaving requester 0 favoured for the tie test.
    step(0, 0, 0, 4'd0, 16'd0, 1, 0, 0, 4'd0, 16'd0);
    chk("solo1_gnt1", {31'd0, gnt1}, 32'd1);
    idle();

    // Both requesting, no lock: alternate 0,1,0,1; second read sees 0xBEEF.
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 4'd5, 16'd0, 1, 0, 1, 4'd5, 16'hBEEF);
      chk("alt_gnt0", {31'd0, gnt0}, {31'd0, (k % 2) == 0});
      chk("alt_gnt1", {31'd0, gnt1}, {31'd0, (k % 2) == 1});
      if (k == 1) chk("alt_rd_old", {16'd0, rdata0}, 32'h3344);
      if (k == 3) chk("alt_rd_new", {16'd0, rdata0}, 32'hBEEF);
    end

    // Lock held for 12 cycles with requester 1 waiting: forced release after 8.
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, 4'(k), 16'd0, 1, 0, 0, 4'd7, 16'd0);
      if (k < 8) begin
        chk("lock_gnt0", {31'd0, gnt0}, 32'd1);
        chk("lock_gnt1", {31'd0, gnt1}, 32'd0);
      end
      if (k == 8) chk("lock_release_gnt1", {31'd0, gnt1}, 32'd1);
      if (k == 9) chk("lock_regrab_gnt0", {31'd0, gnt0}, 32'd1);
    end
    idle();

    // Lock dropped after 3 locked grants: last unlocked access, then requester 1.
    step(0, 0, 0, 4'd0, 16'd0, 1, 0, 0, 4'd2, 16'd0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 4'd1, 16'd0, 1, 0, 0, 4'd2, 16'd0);
      chk("drop_gnt0", {31'd0, gnt0}, 32'd1);
      chk("drop_gnt1", {31'd0, gnt1}, 32'd0);
    end
    step(1, 0, 0, 4'd1, 16'd0, 1, 0, 0, 4'd2, 16'd0);
    chk("drop_last_gnt0", {31'd0, gnt0}, 32'd1);
    step(1, 0, 0, 4'd1, 16'd0, 1, 0, 0, 4'd2, 16'd0);
    chk("drop_next_gnt1", {31'd0, gnt1}, 32'd1);
    idle();

    // Reset in the middle of a locked write sequence.
    step(1, 1, 1, 4'd9, 16'h1234, 1, 0, 0, 4'd2, 16'd0);
    chk("rl_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rl_we", {31'd0, mem_we}, 32'd1);
    step(1, 1, 1, 4'd9, 16'h5678, 1, 0, 0, 4'd2, 16'd0);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("rl_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    chk("rl_rst_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    req0 = 1; lock0 = 0; we0 = 0; addr0 = 4'd9;
    req1 = 1; lock1 = 0; we1 = 0; addr1 = 4'd2;
    @(negedge clk);
    chk("rl_tie_gnt0", {31'd0, gnt0}, 32'd1);
    idle();
    chk("rl_rdata0", {16'd0, rdata0}, {16'd0, preload(9)});

    // Mixed traffic, checked by the model only.
    for (int k = 0; k < 80; k++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
